demux14_enable: RTL and testbench



---
 rtl/demux14_enable.sv | 40 ++++
 tb/tb_demux14_enable.sv | 124 ++++++++++++
 2 files changed

// File: rtl/demux14_enable.sv
// demux14_enable: registered 1-to-4 demultiplexer with active-low enable.
// Define DEMUX14_SYNC_IN_EN to pass i through a two-flop synchronizer first.
module demux14_enable (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       i,
    input  logic [1:0] s,
    output logic [3:0] y
);
    logic       i_eff;
    logic [3:0] y_next;
`ifdef DEMUX14_SYNC_IN_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= '0;
        else sync <= {sync[0], i};
    assign i_eff = sync[1];
`else
    assign i_eff = i;
`endif
    // case (not ==) so an unknown e or s falls to the zero default instead of X
    always_comb begin
        y_next = '0;
        case (e)
            1'b0:
                case (s)
                    2'd0:    y_next = {3'b000, i_eff};
                    2'd1:    y_next = {2'b00, i_eff, 1'b0};
                    2'd2:    y_next = {1'b0, i_eff, 2'b00};
                    2'd3:    y_next = {i_eff, 3'b000};
                    default: y_next = '0;
                endcase
            default: y_next = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) y <= '0;
        else y <= y_next;
endmodule

// File: tb/tb_demux14_enable.sv
// tb_demux14_enable: checks demux14_enable against a per-edge model plus literal expectations.
module tb_demux14_enable;
    logic       clk = 0;
    logic       rst = 0;
    logic       e = 0;
    logic       i = 0;
    logic [1:0] s = 0;
    logic [3:0] y;
    logic [3:0] exp_y = 0;
    logic [1:0] i_hist = 0;
    int checks = 0;
    int errors = 0;

    demux14_enable dut (.clk(clk), .rst(rst), .e(e), .i(i), .s(s), .y(y));

    always #5 clk = ~clk;

    // Model: the bit the demux sees is i itself, or i from two edges earlier when synchronized.
    function automatic logic [3:0] route(input logic en_n, input logic [1:0] sel, input logic bit_in);
        if (en_n !== 1'b0 || $isunknown(sel)) return 4'b0000;
        return 4'(bit_in) << sel;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            exp_y <= '0;
            i_hist <= '0;
        end else begin
`ifdef DEMUX14_SYNC_IN_EN
            exp_y <= route(e, s, i_hist[1]);
`else
            exp_y <= route(e, s, i);
`endif
            i_hist <= {i_hist[0], i};
        end

    always @(negedge clk) begin
        checks++;
        if (y !== exp_y) begin
            errors++;
            $display("FAIL model_cmp t=%0t y=%b expected=%b", $time, y, exp_y);
        end
        checks++;
        if ($isunknown(y) || $countones(y) > 1) begin
            errors++;
            $display("FAIL onehot t=%0t y=%b expected zero or one-hot", $time, y);
        end
    end

    task automatic chk(input string name, input logic [3:0] want);
        checks++;
        if (y !== want) begin
            errors++;
            $display("FAIL %s t=%0t y=%b expected=%b", name, $time, y, want);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        e = 0; s = 1; i = 1;
        #1 rst = 1;
        #1 chk("reset_immediate", 4'b0000);
        edges(3);
        chk("reset_held", 4'b0000);
        rst = 0;
        edges(3);
        chk("after_release", 4'b0010);

        e = 1; s = 0;
        for (int k = 0; k < 8; k++) begin
            i = ~i;
            edges(1);
            chk("disabled", 4'b0000);
        end

        e = 0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            for (int c = 0; c < 10; c++) begin
                i = ~i;
                edges(1);
            end
        end
        i = 1;
        s = 1;
        edges(3);
        chk("sweep_s1_hold", 4'b0010);

        s = 2'bx; i = 1;
        edges(1);
        checks++;
        if ($isunknown(y)) begin
            errors++;
            $display("FAIL unknown_sel y=%b expected no X", y);
        end
        if ($isunknown(s)) chk("unknown_sel_zero", 4'b0000);

        s = 2; i = 1; e = 0;
        edges(3);
        chk("en_on", 4'b0100);
        e = 1;
        edges(1);
        chk("en_off", 4'b0000);
        e = 0;
        edges(1);
        chk("en_back", 4'b0100);

        s = 3;
        edges(3);
        chk("pre_reset", 4'b1000);
        rst = 1;
        #1 chk("midrun_reset", 4'b0000);
        #1 rst = 0;
        edges(3);
        chk("resume", 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
